// File: rtl/param_core_if.sv
// Instruction and data-memory bus of param_core, grouped for port hookup.
// Carries the instruction valid/ready handshake and the memory request/ack port.
// Modport master: feeder + memory model side. Modport slave: the core.
//   instruction[15:0], instr_valid, instr_ready : instruction handshake
//   mem_req, mem_we, mem_addr, mem_wdata         : memory request, held until ack
//   mem_ack, mem_rdata                           : memory completion, load data
interface param_core_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [15:0]       instruction;
  logic              instr_valid;
  logic              instr_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output instruction, instr_valid,
    input  instr_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

  modport slave (
    input  instruction, instr_valid,
    output instr_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );
endinterface

// File: rtl/param_core.sv
// Multi-cycle 8-register processor with DATA_W-wide datapath, external data memory.
// Latency: ALU/MVI done 3 cycles after handshake; load/store 3 + memory wait cycles.
// Backpressure: instr_ready only in IDLE with run=1; run=0 freezes all states but MEM.
// Ports: clk, reset (async active-low), run, bus (param_core_if.slave: instruction
//   handshake + memory request/ack), dbg_sel/dbg_reg (combinational register peek),
//   reg_c_out (result register), done (retire pulse), busy (state != IDLE).
// Instruction: [15:13] Rx, [12:10] Ry, [12:5] imm8, [4:2] sel, [1:0] format
//   format 0 = ALU Rx,Ry; 1 = ALU Rx,imm8; 2 = MVI Rx,imm8; 3 = memory (sel[0]=1 store).
// Optional: define CORE_DPI_CHECK_EN to cross-check ALU results against an
//   independent reference model (simulation only, DATA_W <= 32). Undefined by default.
module param_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  param_core_if.slave       bus,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_reg,
  output logic [DATA_W-1:0] reg_c_out,
  output logic              done,
  output logic              busy
);
  localparam int SHAMT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} state_t;

  state_t            state;
  logic [15:0]       reg_i;
  logic [DATA_W-1:0] reg_s;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] reg_c;
  logic [DATA_W-1:0] regs [8];
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [2:0]        rx;
  logic [2:0]        ry;
  logic [2:0]        sel;
  logic [1:0]        fmt;
  logic [DATA_W-1:0] imm_ext;

  assign rx      = reg_i[15:13];
  assign ry      = reg_i[12:10];
  assign sel     = reg_i[4:2];
  assign fmt     = reg_i[1:0];
  assign imm_ext = DATA_W'(reg_i[12:5]);

  function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [2:0]        op);
    logic [DATA_W-1:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = a << b[SHAMT_W-1:0];
      3'd6:    r = a >> b[SHAMT_W-1:0];
      default: r = (a < b) ? DATA_W'(1) : DATA_W'(0);
    endcase
    return r;
  endfunction

  assign bus.instr_ready = run && (state == IDLE) && reset;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign dbg_reg         = regs[dbg_sel];
  assign reg_c_out       = reg_c;
  assign busy            = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      reg_i       <= '0;
      reg_s       <= '0;
      operand     <= '0;
      reg_c       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done        <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (run && bus.instr_valid) begin
            reg_i <= bus.instruction;
            state <= READ;
          end
        end
        READ: begin
          if (run) begin
            reg_s   <= regs[rx];
            operand <= (fmt == 2'd1 || fmt == 2'd2) ? imm_ext : regs[ry];
            if (fmt == 2'd3) begin
              // Memory outputs are registered on entry so they are valid in the
              // first MEM cycle and stay put until the ack.
              mem_req_q   <= 1'b1;
              mem_we_q    <= reg_i[2];
              mem_addr_q  <= ADDR_W'(regs[ry]);
              mem_wdata_q <= regs[rx];
              state       <= MEM;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (run) begin
            reg_c <= (fmt == 2'd2) ? operand : alu(reg_s, operand, sel);
            state <= WB;
          end
        end
        MEM: begin
          // A started transaction finishes even with run low.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!reg_i[2]) reg_c <= bus.mem_rdata;
            state <= WB;
          end
        end
        WB: begin
          if (run) begin
            if (!(fmt == 2'd3 && reg_i[2])) regs[rx] <= reg_c;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CORE_DPI_CHECK_EN
  function automatic int ref_alu(input int a, input int b, input int op);
    int unsigned ua;
    int unsigned ub;
    ua = a;
    ub = b;
    case (op)
      0:       return int'(ua + ub);
      1:       return int'(ua - ub);
      2:       return int'(ua & ub);
      3:       return int'(ua | ub);
      4:       return int'(ua ^ ub);
      5:       return int'(ua << (ub % DATA_W));
      6:       return int'(ua >> (ub % DATA_W));
      default: return (ua < ub) ? 1 : 0;
    endcase
  endfunction

  int                ref_res;
  logic [DATA_W-1:0] rtl_res;

  always @(posedge clk) begin
    if (reset && run && state == EXEC && !reg_i[1]) begin
      ref_res = ref_alu(int'(reg_s), int'(operand), int'(sel));
      rtl_res = alu(reg_s, operand, sel);
      if (DATA_W'(ref_res) !== rtl_res)
        $error("ALU check: reg_i=%h reg_s=%h operand=%h sel=%0d ref=%h rtl=%h",
               reg_i, reg_s, operand, sel, DATA_W'(ref_res), rtl_res);
    end
  end
`endif
endmodule

// File: tb/tb_param_core.sv
module tb_param_core;
  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [2:0]    dbg_sel;
  logic [DW-1:0] dbg_reg;
  logic [DW-1:0] reg_c_out;
  logic          done;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Architectural view of the register file, updated per retired instruction.
  logic [DW-1:0] mdl [8];

  param_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  param_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .run       (run),
    .bus       (bus),
    .dbg_sel   (dbg_sel),
    .dbg_reg   (dbg_reg),
    .reg_c_out (reg_c_out),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[3:0];
      3'd6:    return a >> b[3:0];
      default: return (a < b) ? DW'(1) : DW'(0);
    endcase
  endfunction

  function automatic logic [15:0] enc(input logic [1:0] fmt, input logic [2:0] rx,
                                      input logic [7:0] mid, input logic [2:0] sel);
    return {rx, mid, sel, fmt};
  endfunction

  function automatic logic [7:0] ry_field(input logic [2:0] ry);
    return {ry, 5'b00000};
  endfunction

  // Issues one instruction, plays the memory side, and checks latency, memory
  // request contents, result and register file effect against the model.
  task automatic do_instr(input logic [15:0] ins, input int wait_n, input logic [DW-1:0] rdata);
    logic [2:0]    rx;
    logic [2:0]    ry;
    logic [2:0]    sel;
    logic [1:0]    fmt;
    logic [7:0]    imm;
    logic          is_store;
    logic [DW-1:0] expv;
    int            exp_lat;
    int            lat;
    int            waits;
    bit            acked;
    rx = ins[15:13]; ry = ins[12:10]; sel = ins[4:2]; fmt = ins[1:0]; imm = ins[12:5];
    is_store = (fmt == 2'd3) && sel[0];
    lat = -1; waits = 0; acked = 0;
    case (fmt)
      2'd0:    expv = ref_alu(mdl[rx], mdl[ry], sel);
      2'd1:    expv = ref_alu(mdl[rx], DW'(imm), sel);
      2'd2:    expv = DW'(imm);
      default: expv = rdata;
    endcase
    exp_lat = (fmt == 2'd3) ? 3 + wait_n : 3;

    @(negedge clk);
    bus.instruction = ins;
    bus.instr_valid = 1'b1;
    #1 check("instr_ready_idle", bus.instr_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instruction = 16'($urandom);
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) check("busy_running", busy, 1'b1);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        acked = 1;
      end
      if (done) lat = c;
      else if (bus.mem_req && !acked) begin
        check("mem_we", bus.mem_we, is_store);
        check("mem_addr", bus.mem_addr, AW'(mdl[ry]));
        if (is_store) check("mem_wdata", bus.mem_wdata, mdl[rx]);
        if (waits == wait_n) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
        end
        waits++;
      end
    end
    bus.mem_ack = 1'b0;
    check("latency", lat, exp_lat);
    check("mem_req_cycles", waits, (fmt == 2'd3) ? wait_n + 1 : 0);
    if (!is_store) begin
      mdl[rx] = expv;
      check("reg_c_out", reg_c_out, expv);
    end
    dbg_sel = rx;
    #1 check("dbg_reg_rx", dbg_reg, mdl[rx]);
    @(posedge clk);
    #1 check("done_single_pulse", done, 1'b0);
  endtask

  initial begin
    logic [15:0] ins;
    int          lat;
    int          r;
    logic [1:0]  fmt;
    logic [2:0]  sel;

    for (int i = 0; i < 8; i++) mdl[i] = '0;
    rst_n = 1'b0;
    run = 1'b0;
    dbg_sel = 3'd0;
    bus.instruction = '0;
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_instr_ready", bus.instr_ready, 1'b0);
    check("rst_reg_c", reg_c_out, 0);
    check("rst_dbg_reg", dbg_reg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
    #1 check("ready_after_release", bus.instr_ready, 1'b1);

    // ADDI R1, 5 from zero
    do_instr(enc(2'd1, 3'd1, 8'h05, 3'd0), 0, '0);
    check("r1_is_5", mdl[1], 16'h0005);

    // R1 = 0 - 1 = 0xFFFF, R2 = 2, ADD R1,R2 wraps to 1
    do_instr(enc(2'd2, 3'd1, 8'h00, 3'd0), 0, '0);
    do_instr(enc(2'd1, 3'd1, 8'h01, 3'd1), 0, '0);
    do_instr(enc(2'd2, 3'd2, 8'h02, 3'd0), 0, '0);
    do_instr(enc(2'd0, 3'd1, ry_field(3'd2), 3'd0), 0, '0);
    check("add_wrap", mdl[1], 16'h0001);

    // Store R4 -> [R3] with 3 wait cycles, then loads back
    do_instr(enc(2'd2, 3'd3, 8'h40, 3'd0), 0, '0);
    do_instr(enc(2'd2, 3'd4, 8'hAB, 3'd0), 0, '0);
    do_instr(enc(2'd3, 3'd4, ry_field(3'd3), 3'd1), 3, 16'h5555);
    do_instr(enc(2'd3, 3'd5, ry_field(3'd3), 3'd0), 3, 16'h00AB);
    check("load_r5", mdl[5], 16'h00AB);
    do_instr(enc(2'd3, 3'd6, ry_field(3'd3), 3'd0), 0, 16'hBEEF);

    // Stall in EXEC: ADDI R7, 0x22 on top of R7 = 0x33
    do_instr(enc(2'd2, 3'd7, 8'h33, 3'd0), 0, '0);
    ins = enc(2'd1, 3'd7, 8'h22, 3'd0);
    @(negedge clk);
    bus.instruction = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 run = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_no_done", done, 1'b0);
      check("stall_busy", busy, 1'b1);
    end
    run = 1'b1;
    lat = -1;
    for (int c = 1; c <= 3 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (done) lat = c;
    end
    check("stall_resume_done", (lat >= 1 && lat <= 2), 1'b1);
    mdl[7] = 16'h0055;
    check("stall_result", reg_c_out, 16'h0055);
    @(posedge clk);
    #1 check("stall_done_once", done, 1'b0);

    // Randomised mix against the model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      sel = 3'($urandom_range(0, 7));
      if (r < 3)      fmt = 2'd0;
      else if (r < 5) fmt = 2'd1;
      else if (r < 7) fmt = 2'd2;
      else begin
        fmt = 2'd3;
        sel = (r == 9) ? 3'd1 : 3'd0;
      end
      ins = enc(fmt, 3'($urandom_range(0, 7)), 8'($urandom), sel);
      do_instr(ins, $urandom_range(0, 3), DW'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1 check("final_regfile", dbg_reg, mdl[i]);
    end

    // Reset while a load waits for its ack
    dbg_sel = 3'd6;
    @(negedge clk);
    bus.instruction = enc(2'd3, 3'd6, ry_field(3'd3), 3'd0);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 check("midmem_req_high", bus.mem_req, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmem_req_dropped", bus.mem_req, 1'b0);
    check("midmem_busy", busy, 1'b0);
    check("midmem_dest_reg", dbg_reg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midmem_ready_again", bus.instr_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
